// File: rtl/pio_fifo.sv
// Show-ahead FIFO between the Wishbone register block and one PIO state machine.
// Head word is presented combinationally; level is a separate counter driving full/empty/threshold.
module pio_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pull,
  output logic [WIDTH-1:0] pull_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level,
  input  logic [LW-1:0]    thresh,
  output logic             at_thresh,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_overflow;
  logic             r_underflow;

  logic w_empty;
  logic w_full;
  logic w_pull_ok;
  logic w_push_ok;

  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == DEPTH_L);
  assign w_pull_ok = pull & ~w_empty;
  // A pull from a full FIFO frees the slot the simultaneous push lands in.
  assign w_push_ok = push & (~w_full | w_pull_ok);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clear) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pull_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pull_ok})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (push && !w_push_ok) r_overflow  <= 1'b1;
      if (pull && !w_pull_ok) r_underflow <= 1'b1;
    end
  end

  // Storage is deliberately left unreset; pointers alone define validity.
  always_ff @(posedge wb_clk_i) begin
    if (w_push_ok && !clear && !wb_rst_i) r_mem[r_wr_ptr] <= push_data;
  end

  assign pull_data = w_empty ? '0 : r_mem[r_rd_ptr];
  assign full      = w_full;
  assign empty     = w_empty;
  assign level     = r_level;
  assign at_thresh = (r_level >= thresh);
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule
